lfsr_keystream: RTL and testbench

Galois LFSR keystream generator. Produces one pseudo-random bit per handshake to feed the XOR stage of the bitstream scrambler/cipher path: ciphertext = plaintext XOR ks_bit.
Supports seed loading and pause/resume. Uses a valid/ready handshake on the keystream output so a downstream stall never drops or repeats a bit.

---
 rtl/lfsr_pkg.sv | 15 +
 rtl/lfsr_step.sv | 15 +
 rtl/lfsr_keystream.sv | 96 +++++++++
 tb/tb_lfsr_keystream.sv | 192 +++++++++++++++++++
 4 files changed

// File: rtl/lfsr_pkg.sv
// Shared FSM encoding and default 16-bit polynomial constants for the keystream LFSR.
// Imported by the keystream top and its step function.
package lfsr_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      HOLD = 2'd1,
      RUN  = 2'd2
   } ks_state_e;

   // x^16 + x^14 + x^13 + x^11 + 1, maximal length
   localparam logic [15:0] TAPS_16 = 16'hB400;
   localparam logic [15:0] SEED_16 = 16'hACE1;

endpackage

// File: rtl/lfsr_step.sv
// One right-shift step of a Galois LFSR.
// The feedback mask is applied when the bit shifted out is 1.
module lfsr_step #(
   parameter int unsigned WIDTH = 16
) (
   input  logic [WIDTH-1:0] cur,
   input  logic [WIDTH-1:0] taps,
   output logic [WIDTH-1:0] nxt
);

   always_comb begin
      nxt = (cur >> 1) ^ (cur[0] ? taps : '0);
   end

endmodule

// File: rtl/lfsr_keystream.sv
// Galois LFSR keystream generator with seed loading, pause/resume and a valid/ready output.
// All outputs derive from registers only; there is no input-to-output combinational path.
module lfsr_keystream
   import lfsr_pkg::*;
#(
   parameter int unsigned     WIDTH        = 16,
   parameter logic [WIDTH-1:0] TAPS         = TAPS_16,
   parameter logic [WIDTH-1:0] DEFAULT_SEED = SEED_16,
   parameter int unsigned     CNT_W        = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             seed_valid,
   input  logic [WIDTH-1:0] seed,
   output logic             seed_ready,
   input  logic             enable,
   output logic             ks_valid,
   input  logic             ks_ready,
   output logic             ks_bit,
   output logic [WIDTH-1:0] state_out,
   output logic [CNT_W-1:0] bit_count,
   output logic             zero_seed_err
);

   ks_state_e        state_q, state_d;
   logic [WIDTH-1:0] lfsr_q, lfsr_d, lfsr_shift;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             zerr_q, zerr_d;
   logic             seed_accept, xfer, seed_zero;

   lfsr_step #(
      .WIDTH(WIDTH)
   ) u_step (
      .cur (lfsr_q),
      .taps(TAPS),
      .nxt (lfsr_shift)
   );

   assign ks_valid      = (state_q == RUN);
   assign seed_ready    = (state_q != RUN);
   assign ks_bit        = lfsr_q[0] & ks_valid;
   assign state_out     = lfsr_q;
   assign bit_count     = cnt_q;
   assign zero_seed_err = zerr_q;

   assign seed_accept = seed_valid & seed_ready;
   assign xfer        = ks_valid & ks_ready;
   assign seed_zero   = (seed == '0);

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         IDLE: begin
            if (seed_accept) state_d = enable ? RUN : HOLD;
         end
         HOLD: begin
            if (seed_accept) state_d = enable ? RUN : HOLD;
            else if (enable) state_d = RUN;
         end
         RUN: begin
            // A pending bit is always delivered before pausing
            if (ks_ready && !enable) state_d = HOLD;
         end
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      lfsr_d = lfsr_q;
      cnt_d  = cnt_q;
      zerr_d = 1'b0;
      if (seed_accept) begin
         lfsr_d = seed_zero ? DEFAULT_SEED : seed;
         cnt_d  = '0;
         zerr_d = seed_zero;
      end else if (xfer) begin
         lfsr_d = lfsr_shift;
         cnt_d  = cnt_q + CNT_W'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         lfsr_q  <= DEFAULT_SEED;
         cnt_q   <= '0;
         zerr_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         lfsr_q  <= lfsr_d;
         cnt_q   <= cnt_d;
         zerr_q  <= zerr_d;
      end
   end

endmodule

// File: tb/tb_lfsr_keystream.sv
// Directed bench for lfsr_keystream with hand-computed expected LFSR states and bits.
module tb_lfsr_keystream;

   logic        clk = 1'b0;
   logic        rst;
   logic        seed_valid;
   logic [15:0] seed;
   logic        seed_ready;
   logic        enable;
   logic        ks_valid;
   logic        ks_ready;
   logic        ks_bit;
   logic [15:0] state_out;
   logic [15:0] bit_count;
   logic        zero_seed_err;

   int n_checks = 0;
   int n_bad    = 0;

   always #5 clk = ~clk;

   lfsr_keystream u_dut (
      .clk          (clk),
      .rst          (rst),
      .seed_valid   (seed_valid),
      .seed         (seed),
      .seed_ready   (seed_ready),
      .enable       (enable),
      .ks_valid     (ks_valid),
      .ks_ready     (ks_ready),
      .ks_bit       (ks_bit),
      .state_out    (state_out),
      .bit_count    (bit_count),
      .zero_seed_err(zero_seed_err)
   );

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      step();
      rst = 1'b0;
   endtask

   // ACE1 stream: states and the bit each presents
   logic [15:0] ace_st  [7] = '{16'hACE1, 16'hE270, 16'h7138, 16'h389C, 16'h1C4E, 16'h0E27, 16'hB313};
   logic        ace_bit [7] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};

   initial begin
      int zero_seen;
      rst = 1'b1; seed_valid = 1'b0; seed = '0; enable = 1'b0; ks_ready = 1'b0;
      step();
      step();
      rst = 1'b0;

      check_eq("rst_valid", 32'(ks_valid), 32'd0);
      check_eq("rst_bit", 32'(ks_bit), 32'd0);
      check_eq("rst_seed_ready", 32'(seed_ready), 32'd1);
      check_eq("rst_state", 32'(state_out), 32'hACE1);
      check_eq("rst_count", 32'(bit_count), 32'd0);
      check_eq("rst_zerr", 32'(zero_seed_err), 32'd0);

      // Seed ACE1 with enable: first bit one cycle later
      seed_valid = 1'b1; seed = 16'hACE1; enable = 1'b1;
      step();
      seed_valid = 1'b0;
      check_eq("run_valid", 32'(ks_valid), 32'd1);
      check_eq("run_seed_ready", 32'(seed_ready), 32'd0);
      ks_ready = 1'b1;
      for (int i = 0; i < 4; i++) begin
         check_eq("seq_state", 32'(state_out), 32'(ace_st[i]));
         check_eq("seq_bit", 32'(ks_bit), 32'(ace_bit[i]));
         check_eq("seq_count", 32'(bit_count), 32'(i));
         step();
      end

      // Stall for 5 cycles: everything frozen
      ks_ready = 1'b0;
      for (int i = 0; i < 5; i++) begin
         step();
         check_eq("stall_valid", 32'(ks_valid), 32'd1);
         check_eq("stall_state", 32'(state_out), 32'h1C4E);
         check_eq("stall_bit", 32'(ks_bit), 32'd0);
         check_eq("stall_count", 32'(bit_count), 32'd4);
      end
      ks_ready = 1'b1;
      for (int i = 4; i < 7; i++) begin
         check_eq("resume_state", 32'(state_out), 32'(ace_st[i]));
         check_eq("resume_bit", 32'(ks_bit), 32'(ace_bit[i]));
         check_eq("resume_count", 32'(bit_count), 32'(i));
         if (i < 6) step();
      end

      // Drop enable while stalled: stays in RUN until the pending bit goes
      ks_ready = 1'b0; enable = 1'b0;
      step();
      check_eq("pause_wait_valid", 32'(ks_valid), 32'd1);
      check_eq("pause_wait_state", 32'(state_out), 32'hB313);
      check_eq("pause_wait_bit", 32'(ks_bit), 32'd1);
      ks_ready = 1'b1;
      step();
      ks_ready = 1'b0;
      check_eq("hold_valid", 32'(ks_valid), 32'd0);
      check_eq("hold_seed_ready", 32'(seed_ready), 32'd1);
      check_eq("hold_state", 32'(state_out), 32'hED89);
      check_eq("hold_count", 32'(bit_count), 32'd7);
      check_eq("hold_bit", 32'(ks_bit), 32'd0);

      // Reseed 0001 in HOLD
      seed_valid = 1'b1; seed = 16'h0001;
      step();
      seed_valid = 1'b0;
      check_eq("reseed_state", 32'(state_out), 32'h0001);
      check_eq("reseed_count", 32'(bit_count), 32'd0);
      check_eq("reseed_valid", 32'(ks_valid), 32'd0);
      check_eq("reseed_zerr", 32'(zero_seed_err), 32'd0);
      enable = 1'b1;
      step();
      check_eq("hold_run_valid", 32'(ks_valid), 32'd1);
      check_eq("hold_run_bit", 32'(ks_bit), 32'd1);
      ks_ready = 1'b1;
      step();
      check_eq("s0001_state", 32'(state_out), 32'hB400);
      check_eq("s0001_count", 32'(bit_count), 32'd1);

      // Zero seed in IDLE substitutes the default and pulses the error once
      ks_ready = 1'b0; enable = 1'b0;
      do_reset();
      seed_valid = 1'b1; seed = 16'h0000; enable = 1'b1;
      step();
      seed_valid = 1'b0;
      check_eq("zseed_err_hi", 32'(zero_seed_err), 32'd1);
      check_eq("zseed_state", 32'(state_out), 32'hACE1);
      step();
      check_eq("zseed_err_lo", 32'(zero_seed_err), 32'd0);
      ks_ready = 1'b1;
      for (int i = 0; i < 4; i++) begin
         check_eq("zseq_state", 32'(state_out), 32'(ace_st[i]));
         check_eq("zseq_bit", 32'(ks_bit), 32'(ace_bit[i]));
         step();
      end

      // Full period from ACE1
      ks_ready = 1'b0; enable = 1'b0;
      do_reset();
      seed_valid = 1'b1; seed = 16'hACE1; enable = 1'b1; ks_ready = 1'b1;
      step();
      seed_valid = 1'b0;
      zero_seen = 0;
      for (int i = 0; i < 65535; i++) begin
         step();
         if (state_out == 16'h0000) zero_seen++;
      end
      check_eq("wrap_zero_state", 32'(zero_seen), 32'd0);
      check_eq("wrap_state", 32'(state_out), 32'hACE1);
      check_eq("wrap_count", 32'(bit_count), 32'hFFFF);
      step();
      check_eq("wrap1_state", 32'(state_out), 32'hE270);
      check_eq("wrap1_count", 32'(bit_count), 32'd0);

      // Reset mid-run while stalled
      ks_ready = 1'b0;
      step();
      rst = 1'b1;
      step();
      rst = 1'b0;
      check_eq("midrst_valid", 32'(ks_valid), 32'd0);
      check_eq("midrst_state", 32'(state_out), 32'hACE1);
      check_eq("midrst_count", 32'(bit_count), 32'd0);
      check_eq("midrst_seed_ready", 32'(seed_ready), 32'd1);
      enable = 1'b1;
      step();
      step();
      check_eq("idle_enable_valid", 32'(ks_valid), 32'd0);
      check_eq("idle_enable_seed_ready", 32'(seed_ready), 32'd1);

      $display("test done: total=%0d bad=%0d", n_checks, n_bad);
      $finish;
   end

endmodule
